reg_file_sb: RTL and testbench

- Parametrised general-purpose register file with an integrated scoreboard for RAW hazard detection.
- Provides NUM_RD combinational read ports and one synchronous write port.
- Tracks the destinations of in-flight instructions in a HAZ_DEPTH-deep shift register and raises a per-port pause toward the decode stage.
- Sits between decode and writeback; successor to the fixed 2-port/3-stage register file, adding flush, a port-enable mask, self-inserted bubbles and optional write-through bypass.

---
 rtl/reg_file_sb.sv | 64 ++++++
 tb/tb_reg_file_sb.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// reg_file_sb: register file with NUM_RD combinational read ports, one write port and a RAW-hazard scoreboard
// Ports: clk, rst (sync, active-high); rd_addr/rd_used/rd_data per read port; we/wr_addr/wr_data write port;
//        issue_valid/issue_dst/flush feed the scoreboard; pause (per port) and stall (OR of pause) go to decode.
// Option: define REGFILE_BYPASS_EN for write-through bypass; the oldest slot is then excluded from the hazard compare.
module reg_file_sb #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int NUM_RD    = 2,
  parameter int HAZ_DEPTH = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  input  logic [NUM_RD-1:0]        rd_used,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     issue_valid,
  input  logic [ADDR_W-1:0]        issue_dst,
  input  logic                     flush,
  output logic [NUM_RD-1:0]        pause,
  output logic                     stall
);
`ifdef REGFILE_BYPASS_EN
  localparam int NCMP = HAZ_DEPTH - 1;
`else
  localparam int NCMP = HAZ_DEPTH;
`endif
  logic [DATA_W-1:0] regs [2**ADDR_W];
  logic [ADDR_W-1:0] sb [HAZ_DEPTH];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**ADDR_W; i++) regs[i] <= '0;
    end else if (we && wr_addr != '0) begin
      regs[wr_addr] <= wr_data;
    end
  end
  // A stalled instruction enters as a bubble so it can re-present next cycle.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < HAZ_DEPTH; i++) sb[i] <= '0;
    end else begin
      sb[0] <= (issue_valid && !stall) ? issue_dst : '0;
      for (int i = 1; i < HAZ_DEPTH; i++) sb[i] <= sb[i-1];
    end
  end
  for (genvar k = 0; k < NUM_RD; k++) begin : g_port
    logic [ADDR_W-1:0] ra;
    logic              hit;
    assign ra = rd_addr[k*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
    assign rd_data[k*DATA_W +: DATA_W] = ra == '0 ? '0 : (we && wr_addr == ra) ? wr_data : regs[ra];
`else
    assign rd_data[k*DATA_W +: DATA_W] = ra == '0 ? '0 : regs[ra];
`endif
    always_comb begin
      hit = 1'b0;
      for (int i = 0; i < NCMP; i++) hit = hit | (sb[i] == ra);
    end
    assign pause[k] = issue_valid && rd_used[k] && ra != '0 && hit;
  end
  assign stall = |pause;
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: randomized and directed checks of reg_file_sb against a queue-based reference model
module tb_reg_file_sb;
  localparam int DW = 32, AW = 5, NR = 2, HD = 3;
`ifdef REGFILE_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif
  localparam int NCMP = HD - BYP;
  logic clk = 0, rst = 1;
  logic [NR*AW-1:0] rd_addr = '0;
  logic [NR-1:0] rd_used = '0;
  logic [NR*DW-1:0] rd_data;
  logic we = 0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic issue_valid = 0;
  logic [AW-1:0] issue_dst = '0;
  logic flush = 0;
  logic [NR-1:0] pause;
  logic stall;
  int n_chk = 0, n_err = 0;
  logic [DW-1:0] mreg [2**AW];
  logic [AW-1:0] msb [$];

  reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .HAZ_DEPTH(HD)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_used(rd_used), .rd_data(rd_data),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .issue_valid(issue_valid),
    .issue_dst(issue_dst), .flush(flush), .pause(pause), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    foreach (mreg[i]) mreg[i] = '0;
    msb.delete();
    repeat (HD) msb.push_back('0);
  endtask

  function automatic logic [NR-1:0] exp_pause();
    logic [NR-1:0] p = '0;
    for (int k = 0; k < NR; k++) begin
      logic [AW-1:0] a = rd_addr[k*AW +: AW];
      for (int i = 0; i < NCMP; i++)
        if (issue_valid && rd_used[k] && a != '0 && msb[i] == a) p[k] = 1'b1;
    end
    return p;
  endfunction

  function automatic logic [DW-1:0] exp_rd(input int k);
    logic [AW-1:0] a = rd_addr[k*AW +: AW];
    if (a == '0) return '0;
    if (BYP == 1 && we && wr_addr == a) return wr_data;
    return mreg[a];
  endfunction

  task automatic cycle();
    logic [NR-1:0] p;
    #1;
    p = exp_pause();
    for (int k = 0; k < NR; k++) check($sformatf("rd%0d", k), 64'(rd_data[k*DW +: DW]), 64'(exp_rd(k)));
    check("pause", 64'(pause), 64'(p));
    check("stall", 64'(stall), 64'(|p));
    @(posedge clk);
    if (rst) model_reset();
    else begin
      if (we && wr_addr != '0) mreg[wr_addr] = wr_data;
      if (flush) foreach (msb[i]) msb[i] = '0;
      else begin
        msb.push_front((issue_valid && !(|p)) ? issue_dst : '0);
        void'(msb.pop_back());
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    issue_valid = 0; issue_dst = '0; we = 0; flush = 0; rd_used = '0; rd_addr = '0;
    repeat (n) cycle();
  endtask

  task automatic set_rd(input int k, input logic [AW-1:0] a);
    rd_addr[k*AW +: AW] = a;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);
    cycle();
    rst = 0;
    we = 1; wr_addr = 5; wr_data = 32'hDEADBEEF;
    cycle();
    we = 0; set_rd(0, 5);
    #1 check("pre_rst", 64'(rd_data[DW-1:0]), 64'hDEADBEEF);
    cycle();
    rst = 1; we = 1; wr_addr = 6; wr_data = 32'hCAFEF00D;
    cycle();
    rst = 0; we = 0; set_rd(1, 6);
    #1;
    check("rst_rd", 64'(rd_data[DW-1:0]), 64'h0);
    check("rst_wr_ignored", 64'(rd_data[2*DW-1:DW]), 64'h0);
    check("rst_pause", 64'(pause), 64'h0);
    check("rst_stall", 64'(stall), 64'h0);
    cycle();
    we = 1; wr_addr = 0; wr_data = 32'hFFFFFFFF;
    cycle();
    we = 0; set_rd(0, 0);
    #1 check("x0_rd", 64'(rd_data[DW-1:0]), 64'h0);
    issue_valid = 1; issue_dst = 0;
    cycle();
    rd_used = 2'b01;
    #1 check("x0_pause", 64'(pause), 64'h0);
    cycle();
    idle(HD);
    issue_valid = 1; issue_dst = 7;
    cycle();
    issue_dst = 0; set_rd(0, 7); rd_used = 2'b01;
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) begin we = 1; wr_addr = 7; wr_data = 32'h12345678; end
      #1 check($sformatf("raw_c%0d", c), 64'(pause), (c <= NCMP) ? 64'h1 : 64'h0);
      if (c == 3 && BYP == 1) check("raw_byp", 64'(rd_data[DW-1:0]), 64'h12345678);
      cycle();
    end
    we = 0;
    #1;
    check("raw_c4", 64'(pause), 64'h0);
    check("raw_data", 64'(rd_data[DW-1:0]), 64'h12345678);
    cycle();
    idle(HD);
    issue_valid = 1; issue_dst = 9;
    cycle();
    issue_dst = 0; set_rd(1, 9); rd_used = 2'b10;
    #1 check("mask_on", 64'(pause), 64'h2);
    rd_used = 2'b00;
    #1 check("mask_off", 64'(pause), 64'h0);
    cycle();
    idle(HD);
    issue_valid = 1; issue_dst = 4;
    cycle();
    issue_dst = 0; flush = 1; set_rd(0, 4); rd_used = 2'b01;
    #1 check("flush_cyc", 64'(pause), 64'h1);
    cycle();
    flush = 0;
    #1 check("post_flush", 64'(pause), 64'h0);
    cycle();
    idle(HD);
    issue_valid = 1; issue_dst = 3;
    cycle();
    issue_dst = 11; set_rd(0, 3); set_rd(1, 11); rd_used = 2'b11;
    for (int c = 0; c < NCMP; c++) begin
      #1 check($sformatf("bub_stall%0d", c), 64'(pause), 64'h1);
      cycle();
    end
    #1 check("bub_go", 64'(pause), 64'h0);
    cycle();
    issue_dst = 0; set_rd(0, 0);
    #1 check("bub_11", 64'(pause), 64'h2);
    cycle();
    idle(HD);
    repeat (3000) begin
      rst = $urandom_range(63) == 0;
      flush = $urandom_range(15) == 0;
      we = 1'($urandom_range(1));
      wr_addr = AW'($urandom_range(7));
      wr_data = $urandom;
      issue_valid = $urandom_range(3) != 0;
      issue_dst = AW'($urandom_range(7));
      set_rd(0, AW'($urandom_range(7)));
      set_rd(1, AW'($urandom_range(7)));
      rd_used = NR'($urandom_range(3));
      cycle();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
